// File: rtl/if_fetch_ctrl_pkg.sv
// Shared types and constants for the fetch-stage sequencer: FSM state encoding,
// PC increment and the default halt instruction word.
package if_fetch_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_STEP = 2'd2,
        ST_HALT = 2'd3
    } fetch_state_e;

    localparam int unsigned NB_ADDR_DEF   = 32;
    localparam int unsigned NB_INST_DEF   = 32;
    localparam int unsigned NB_CNT_DEF    = 32;
    localparam int unsigned PC_INCR       = 4;
    localparam logic [31:0] HALT_WORD_DEF = 32'hFFFF_FFFF;

    // RUN and STEP are the only states in which the PC may advance.
    function automatic logic is_fetching(input fetch_state_e s);
        return (s == ST_RUN) || (s == ST_STEP);
    endfunction

endpackage

// File: rtl/if_fetch_ctrl_if.sv
// Bundle between the fetch sequencer and its neighbours: debug unit, hazard/branch
// logic and the IF_pc register. Plain level signals, no handshake.
interface if_fetch_ctrl_if #(
    parameter int NB_ADDR = 32,
    parameter int NB_INST = 32,
    parameter int NB_CNT  = 32
);
    logic               i_run;
    logic               i_step;
    logic               i_stall;
    logic               i_branch_taken;
    logic [NB_ADDR-1:0] i_branch_addr;
    logic               i_jump;
    logic [NB_ADDR-1:0] i_jump_addr;
    logic [NB_ADDR-1:0] i_pc_current;
    logic [NB_INST-1:0] i_inst;

    logic [NB_ADDR-1:0] o_next_pc;
    logic               o_pc_enable;
    logic               o_flush;
    logic               o_halted;
    logic [1:0]         o_state;
    logic [NB_CNT-1:0]  o_fetch_count;

    modport master (
        output i_run, i_step, i_stall, i_branch_taken, i_branch_addr,
               i_jump, i_jump_addr, i_pc_current, i_inst,
        input  o_next_pc, o_pc_enable, o_flush, o_halted, o_state, o_fetch_count
    );

    modport slave (
        input  i_run, i_step, i_stall, i_branch_taken, i_branch_addr,
               i_jump, i_jump_addr, i_pc_current, i_inst,
        output o_next_pc, o_pc_enable, o_flush, o_halted, o_state, o_fetch_count
    );

endinterface

// File: rtl/if_fetch_ctrl_redirect_hold.sv
// Holds one redirect target that arrived while fetch could not advance.
// A newer capture overwrites the held target; capture wins over clear.
module if_fetch_ctrl_redirect_hold #(
    parameter int NB_ADDR = 32
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic               capture_i,
    input  logic [NB_ADDR-1:0] capture_addr_i,
    input  logic               clear_i,
    output logic               valid_o,
    output logic [NB_ADDR-1:0] addr_o
);

    logic               valid_q, valid_d;
    logic [NB_ADDR-1:0] addr_q,  addr_d;

    always_comb begin
        valid_d = valid_q;
        addr_d  = addr_q;
        if (clear_i) begin
            valid_d = 1'b0;
        end
        if (capture_i) begin
            valid_d = 1'b1;
            addr_d  = capture_addr_i;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            valid_q <= 1'b0;
            addr_q  <= '0;
        end else begin
            valid_q <= valid_d;
            addr_q  <= addr_d;
        end
    end

    assign valid_o = valid_q;
    assign addr_o  = addr_q;

endmodule

// File: rtl/if_fetch_ctrl.sv
// Fetch-stage sequencer: run/step/halt FSM, next-PC select (sequential, branch,
// jump, held redirect), PC enable gating and executed-fetch counter.
module if_fetch_ctrl
    import if_fetch_ctrl_pkg::*;
#(
    parameter int               NB_ADDR   = NB_ADDR_DEF,
    parameter int               NB_INST   = NB_INST_DEF,
    parameter int               NB_CNT    = NB_CNT_DEF,
    parameter logic [NB_INST-1:0] HALT_WORD = NB_INST'(HALT_WORD_DEF)
) (
    input  logic           i_clk,
    input  logic           i_reset,
    if_fetch_ctrl_if.slave bus
);

    fetch_state_e       state_q, state_d;
    logic [NB_CNT-1:0]  count_q, count_d;

    logic               fetching;
    logic               halt_inst;
    logic               go;
    logic               redirect_new;
    logic [NB_ADDR-1:0] redirect_addr;
    logic [NB_ADDR-1:0] pc_seq;
    logic [NB_ADDR-1:0] next_pc;
    logic               flush;
    logic               pend_valid;
    logic [NB_ADDR-1:0] pend_addr;
    logic               pend_capture;
    logic               pend_clear;

    assign fetching      = is_fetching(state_q);
    assign halt_inst     = (bus.i_inst == HALT_WORD);
    assign go            = fetching && !bus.i_stall && !halt_inst;
    assign redirect_new  = bus.i_branch_taken || bus.i_jump;
    assign redirect_addr = bus.i_branch_taken ? bus.i_branch_addr : bus.i_jump_addr;
    assign pc_seq        = bus.i_pc_current + NB_ADDR'(PC_INCR);

    // A redirect that cannot be applied now is parked; HALT drops everything.
    assign pend_capture  = redirect_new && !go && (state_q != ST_HALT);
    assign pend_clear    = go || (state_q == ST_HALT);

    if_fetch_ctrl_redirect_hold #(
        .NB_ADDR (NB_ADDR)
    ) u_redirect_hold (
        .clk_i          (i_clk),
        .rst_ni         (i_reset),
        .capture_i      (pend_capture),
        .capture_addr_i (redirect_addr),
        .clear_i        (pend_clear),
        .valid_o        (pend_valid),
        .addr_o         (pend_addr)
    );

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (bus.i_run) begin
                    state_d = ST_RUN;
                end else if (bus.i_step) begin
                    state_d = ST_STEP;
                end
            end
            ST_RUN: begin
                if (halt_inst && !bus.i_stall) begin
                    state_d = ST_HALT;
                end
            end
            ST_STEP: begin
                if (!bus.i_stall) begin
                    state_d = halt_inst ? ST_HALT : ST_IDLE;
                end
            end
            ST_HALT: begin
                state_d = ST_HALT;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // A new redirect takes precedence over a parked one and supersedes it.
    always_comb begin
        next_pc = pc_seq;
        flush   = 1'b0;
        if (go) begin
            if (redirect_new) begin
                next_pc = redirect_addr;
                flush   = 1'b1;
            end else if (pend_valid) begin
                next_pc = pend_addr;
                flush   = 1'b1;
            end
        end
    end

    assign count_d = count_q + {{(NB_CNT-1){1'b0}}, go};

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            state_q <= ST_IDLE;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
        end
    end

    assign bus.o_next_pc     = next_pc;
    assign bus.o_pc_enable   = go;
    assign bus.o_flush       = flush;
    assign bus.o_halted      = (state_q == ST_HALT);
    assign bus.o_state       = state_q;
    assign bus.o_fetch_count = count_q;

endmodule

// File: tb/tb_if_fetch_ctrl.sv
// Directed bench for if_fetch_ctrl: driver pushes expected {flush, next_pc} for every
// cycle that should advance the PC; a negedge monitor checks enable and pops/compares.
module tb_if_fetch_ctrl;
    import if_fetch_ctrl_pkg::*;

    localparam logic [31:0] HALT = 32'hFFFF_FFFF;
    localparam logic [31:0] NOP  = 32'h0000_0013;

    logic clk;
    logic rst_n;

    if_fetch_ctrl_if #(.NB_ADDR(32), .NB_INST(32), .NB_CNT(32)) bus ();

    if_fetch_ctrl #(
        .NB_ADDR   (32),
        .NB_INST   (32),
        .NB_CNT    (32),
        .HALT_WORD (HALT)
    ) dut (
        .i_clk   (clk),
        .i_reset (rst_n),
        .bus     (bus)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // scoreboard
    logic [32:0] exp_q[$];
    logic        exp_go_now;
    int          checks;
    int          errors;

    always @(negedge clk) begin
        logic [32:0] e;
        checks++;
        if (bus.o_pc_enable !== exp_go_now) begin
            errors++;
            $display("FAIL pc_enable act=%b exp=%b t=%0t", bus.o_pc_enable, exp_go_now, $time);
        end
        if (!exp_go_now) begin
            checks++;
            if (bus.o_flush !== 1'b0) begin
                errors++;
                $display("FAIL flush_no_go act=%b exp=0 t=%0t", bus.o_flush, $time);
            end
        end else if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checks++;
            if ({bus.o_flush, bus.o_next_pc} !== e) begin
                errors++;
                $display("FAIL next_pc act=flush %b pc 0x%08h exp=flush %b pc 0x%08h t=%0t",
                         bus.o_flush, bus.o_next_pc, e[32], e[31:0], $time);
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s act=0x%08h exp=0x%08h t=%0t", name, act, exp, $time);
        end
    endtask

    // driver: one clock of inputs plus the expected fetch outcome for that cycle
    task automatic cyc(input logic run, input logic step, input logic stall,
                       input logic [31:0] pc, input logic [31:0] inst,
                       input logic br, input logic [31:0] ba,
                       input logic jmp, input logic [31:0] ja,
                       input logic eg, input logic [31:0] epc, input logic efl);
        bus.i_run          = run;
        bus.i_step         = step;
        bus.i_stall        = stall;
        bus.i_pc_current   = pc;
        bus.i_inst         = inst;
        bus.i_branch_taken = br;
        bus.i_branch_addr  = ba;
        bus.i_jump         = jmp;
        bus.i_jump_addr    = ja;
        exp_go_now         = eg;
        if (eg) exp_q.push_back({efl, epc});
        @(posedge clk);
        #1;
    endtask

    task automatic check_state(input logic [1:0] st);
        check("state", {30'd0, bus.o_state}, {30'd0, st});
    endtask

    initial begin
        checks     = 0;
        errors     = 0;
        exp_go_now = 1'b0;
        rst_n      = 1'b1;
        bus.i_run = 0; bus.i_step = 0; bus.i_stall = 0;
        bus.i_branch_taken = 0; bus.i_branch_addr = '0;
        bus.i_jump = 0; bus.i_jump_addr = '0;
        bus.i_pc_current = '0; bus.i_inst = NOP;

        #2 rst_n = 1'b0;
        #1;
        check_state(2'd0);
        check("reset_count", bus.o_fetch_count, 32'd0);
        check("reset_halted", {31'd0, bus.o_halted}, 32'd0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;

        // continuous sequential fetch
        cyc(1, 0, 0, 32'h0, NOP, 0, 0, 0, 0, 0, 0, 0);
        check_state(2'd1);
        cyc(0, 0, 0, 32'h0, NOP, 0, 0, 0, 0, 1, 32'h4,  0);
        cyc(0, 0, 0, 32'h4, NOP, 0, 0, 0, 0, 1, 32'h8,  0);
        cyc(0, 0, 0, 32'h8, NOP, 0, 0, 0, 0, 1, 32'hC,  0);
        cyc(0, 0, 0, 32'hC, NOP, 0, 0, 0, 0, 1, 32'h10, 0);
        check("count_seq", bus.o_fetch_count, 32'd4);

        // branch held across a stall, applied on release
        cyc(0, 0, 1, 32'h10, NOP, 1, 32'h100, 0, 0, 0, 0, 0);
        cyc(0, 0, 1, 32'h10, NOP, 1, 32'h100, 0, 0, 0, 0, 0);
        cyc(0, 0, 0, 32'h10, NOP, 0, 0, 0, 0, 1, 32'h100, 1);
        check("count_stall", bus.o_fetch_count, 32'd5);
        cyc(0, 0, 0, 32'h100, NOP, 0, 0, 0, 0, 1, 32'h104, 0);

        // priority, jump only, pending overwrite, new redirect supersedes pending
        cyc(0, 0, 0, 32'h104, NOP, 1, 32'h200, 1, 32'h300, 1, 32'h200, 1);
        cyc(0, 0, 0, 32'h200, NOP, 0, 0, 1, 32'h300, 1, 32'h300, 1);
        cyc(0, 0, 1, 32'h300, NOP, 1, 32'h500, 0, 0, 0, 0, 0);
        cyc(0, 0, 1, 32'h300, NOP, 0, 0, 1, 32'h600, 0, 0, 0);
        cyc(0, 0, 0, 32'h300, NOP, 0, 0, 0, 0, 1, 32'h600, 1);
        cyc(0, 0, 1, 32'h600, NOP, 1, 32'h700, 0, 0, 0, 0, 0);
        cyc(0, 0, 0, 32'h600, NOP, 0, 0, 1, 32'h800, 1, 32'h800, 1);
        cyc(0, 0, 0, 32'h800, NOP, 0, 0, 0, 0, 1, 32'h804, 0);
        check("count_redirects", bus.o_fetch_count, 32'd11);

        // asynchronous reset mid-RUN with a redirect parked
        cyc(0, 0, 1, 32'h804, NOP, 1, 32'h900, 0, 0, 0, 0, 0);
        #2 rst_n = 1'b0;
        #1;
        check_state(2'd0);
        check("rst_enable", {31'd0, bus.o_pc_enable}, 32'd0);
        check("rst_flush", {31'd0, bus.o_flush}, 32'd0);
        check("rst_halted", {31'd0, bus.o_halted}, 32'd0);
        check("rst_count", bus.o_fetch_count, 32'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;

        // single step; a surviving pending would show up as 0x900 with flush
        cyc(0, 1, 0, 32'h40, NOP, 0, 0, 0, 0, 0, 0, 0);
        check_state(2'd2);
        cyc(0, 0, 0, 32'h40, NOP, 0, 0, 0, 0, 1, 32'h44, 0);
        check_state(2'd0);
        check("count_step", bus.o_fetch_count, 32'd1);

        // stalled step waits in STEP
        cyc(0, 1, 0, 32'h44, NOP, 0, 0, 0, 0, 0, 0, 0);
        cyc(0, 0, 1, 32'h44, NOP, 0, 0, 0, 0, 0, 0, 0);
        check_state(2'd2);
        cyc(0, 0, 0, 32'h44, NOP, 0, 0, 0, 0, 1, 32'h48, 0);
        check_state(2'd0);

        // redirect captured while IDLE is applied by the next step
        cyc(0, 0, 0, 32'h48, NOP, 1, 32'hA00, 0, 0, 0, 0, 0);
        cyc(0, 1, 0, 32'h48, NOP, 0, 0, 0, 0, 0, 0, 0);
        cyc(0, 0, 0, 32'h48, NOP, 0, 0, 0, 0, 1, 32'hA00, 1);
        check("count_steps", bus.o_fetch_count, 32'd3);

        // run wins over step; PC wrap
        cyc(1, 1, 0, 32'hFFFF_FFFC, NOP, 0, 0, 0, 0, 0, 0, 0);
        check_state(2'd1);
        cyc(0, 0, 0, 32'hFFFF_FFFC, NOP, 0, 0, 0, 0, 1, 32'h0, 0);

        // halt word: stalled first (stay RUN), then halt; debug requests ignored
        cyc(0, 0, 1, 32'h0, HALT, 0, 0, 0, 0, 0, 0, 0);
        check_state(2'd1);
        cyc(0, 0, 0, 32'h0, HALT, 0, 0, 0, 0, 0, 0, 0);
        check_state(2'd3);
        check("halted", {31'd0, bus.o_halted}, 32'd1);
        cyc(1, 1, 0, 32'h0, NOP, 1, 32'hB00, 0, 0, 0, 0, 0);
        cyc(1, 0, 0, 32'h0, NOP, 0, 0, 1, 32'hC00, 0, 0, 0);
        check_state(2'd3);
        check("count_halt", bus.o_fetch_count, 32'd4);

        exp_go_now = 1'b0;
        @(negedge clk);
        #1;
        check("sb_drain", exp_q.size(), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
